// File: rtl/booth_addsub_pipe_if.sv
// Handshake/data bundle for booth_addsub_pipe: operand beat in, result beat out.
// The slave modport is the unit itself; the master modport is whoever feeds and drains it.
interface booth_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_carry;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_op, in_x, in_y, out_ready,
        output in_ready, out_valid, out_res, out_carry, out_ovf
    );

    modport master (
        output in_valid, in_op, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_res, out_carry, out_ovf
    );
endinterface

// File: rtl/booth_addsub_pipe.sv
// Pipelined XOR/ADD/SUB/RSUB unit: one carry segment per stage, elastic valid/ready per stage.
// Optional saturation on signed overflow when BOOTH_ADDSUB_SAT_EN is defined.
module booth_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    booth_addsub_pipe_if.slave  bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_RSUB = 2'b11;

    // Per-stage registers
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic [WIDTH-1:0]  a_reg   [STAGES];
    logic [WIDTH-1:0]  b_reg   [STAGES];
    logic [WIDTH-1:0]  sum_reg [STAGES];
    logic [1:0]        op_reg  [STAGES];
    logic              ovf_reg;

    // What each stage would load this cycle
    logic [STAGES:0]   ready;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_carry;
    logic [STAGES-1:0] carry_next;
    logic [WIDTH-1:0]  src_a    [STAGES];
    logic [WIDTH-1:0]  src_b    [STAGES];
    logic [WIDTH-1:0]  src_sum  [STAGES];
    logic [WIDTH-1:0]  sum_next [STAGES];
    logic [1:0]        src_op   [STAGES];

    logic [WIDTH-1:0]  cond_a;
    logic [WIDTH-1:0]  cond_b;
    logic              cond_cin;
    logic              msb_cin;
    logic              ovf_next;
    logic [WIDTH-1:0]  res_next;

    // Subtraction becomes a + ~b + 1; RSUB just swaps which operand is inverted.
    always_comb begin
        cond_a   = bus.in_x;
        cond_b   = bus.in_y;
        cond_cin = 1'b0;
        case (bus.in_op)
            OP_SUB: begin
                cond_b   = ~bus.in_y;
                cond_cin = 1'b1;
            end
            OP_RSUB: begin
                cond_a   = bus.in_y;
                cond_b   = ~bus.in_x;
                cond_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // Ready ripples backwards from the sink so a drained stage frees its upstream neighbour at once.
    always_comb begin
        ready         = '0;
        ready[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_reg[k] || ready[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SEG:0]     seg_add;
            logic [SEG-1:0]   seg_xor;
            logic [WIDTH-1:0] merged;

            if (gi == 0) begin : g_src_in
                assign src_valid[gi] = bus.in_valid;
                assign src_a[gi]     = cond_a;
                assign src_b[gi]     = cond_b;
                assign src_sum[gi]   = '0;
                assign src_carry[gi] = cond_cin;
                assign src_op[gi]    = bus.in_op;
            end else begin : g_src_reg
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_a[gi]     = a_reg[gi-1];
                assign src_b[gi]     = b_reg[gi-1];
                assign src_sum[gi]   = sum_reg[gi-1];
                assign src_carry[gi] = carry_reg[gi-1];
                assign src_op[gi]    = op_reg[gi-1];
            end

            assign seg_add = {1'b0, src_a[gi][gi*SEG +: SEG]}
                           + {1'b0, src_b[gi][gi*SEG +: SEG]}
                           + {{SEG{1'b0}}, src_carry[gi]};
            assign seg_xor = src_a[gi][gi*SEG +: SEG] ^ src_b[gi][gi*SEG +: SEG];

            always_comb begin
                merged = src_sum[gi];
                merged[gi*SEG +: SEG] = (src_op[gi] == OP_XOR) ? seg_xor : seg_add[SEG-1:0];
            end

            assign sum_next[gi]   = merged;
            assign carry_next[gi] = (src_op[gi] != OP_XOR) && seg_add[SEG];
        end
    endgenerate

    // Carry into the MSB is recoverable from the MSB's own sum bit and operands.
    assign msb_cin  = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ sum_next[LAST][WIDTH-1];
    assign ovf_next = (src_op[LAST] != OP_XOR) && (msb_cin ^ carry_next[LAST]);

`ifdef BOOTH_ADDSUB_SAT_EN
    // On overflow both conditioned operands share a sign, which is the sign of the true result.
    always_comb begin
        res_next = sum_next[LAST];
        if (ovf_next) begin
            res_next = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_next = sum_next[LAST];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            ovf_reg   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                sum_reg[k] <= '0;
                op_reg[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_reg[k] <= src_valid[k];
                    a_reg[k]     <= src_a[k];
                    b_reg[k]     <= src_b[k];
                    sum_reg[k]   <= (k == LAST) ? res_next : sum_next[k];
                    op_reg[k]    <= src_op[k];
                    carry_reg[k] <= carry_next[k];
                end
            end
            if (ready[LAST]) begin
                ovf_reg <= ovf_next;
            end
        end
    end

    assign bus.in_ready  = ready[0] && !rst;
    assign bus.out_valid = valid_reg[LAST];
    assign bus.out_res   = sum_reg[LAST];
    assign bus.out_carry = carry_reg[LAST];
    assign bus.out_ovf   = ovf_reg;
endmodule

// File: tb/tb_booth_addsub_pipe.sv
// Bench for booth_addsub_pipe: directed beats, full-pipe stall, random handshake, reset flush.
// Expected results come from a plain-arithmetic model of XOR/ADD/SUB/RSUB.
module tb_booth_addsub_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    booth_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total  = 0;
    int          bad    = 0;
    int          n_recv = 0;
    int          n_push = 0;
    int          cyc    = 0;
    bit          rand_rdy = 1'b0;
    logic [17:0] exp_q[$];
    logic        held = 1'b0;
    logic [17:0] held_val = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Result packed as {ovf, carry, res}
    function automatic logic [17:0] model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p, q, r;
        logic        c, v;
        int          sr;
        if (op == 2'b00) return {2'b00, x ^ y};
        p = (op == 2'b11) ? y : x;
        q = (op == 2'b11) ? x : y;
        if (op == 2'b01) begin
            r  = x + y;
            c  = (32'(x) + 32'(y)) > 32'h0000_FFFF;
            sr = int'($signed(x)) + int'($signed(y));
        end else begin
            r  = p - q;
            c  = (p >= q);
            sr = int'($signed(p)) - int'($signed(q));
        end
        v = (sr > 32767) || (sr < -32768);
`ifdef BOOTH_ADDSUB_SAT_EN
        if (v) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {v, c, r};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: push on accepted input, pop and compare on accepted output, check stall stability.
    initial forever begin
        logic [17:0] e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'({bus.out_ovf, bus.out_carry, bus.out_res}), 32'(held_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({bus.out_ovf, bus.out_carry, bus.out_res}), 32'(e));
                    n_recv++;
                    $display("beat %0d: res=%h carry=%b ovf=%b", n_recv, bus.out_res, bus.out_carry, bus.out_ovf);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_op, bus.in_x, bus.in_y));
                n_push++;
            end
            held     = bus.out_valid && !bus.out_ready;
            held_val = {bus.out_ovf, bus.out_carry, bus.out_res};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_x     = x;
        bus.in_y     = y;
        @(negedge clk);
        while (!bus.in_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) timeout("send");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) timeout("drain");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] corners [6];
        logic [15:0] x, y;
        logic [1:0]  op;
        int          base;
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};

        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;

        // Model pins
        chk("pin_add",  32'(model(2'b01, 16'h00FF, 16'h0001)), 32'h0_0100);
        chk("pin_sub",  32'(model(2'b10, 16'h0005, 16'h0007)), 32'h0_FFFE);
        chk("pin_rsub", 32'(model(2'b11, 16'h0005, 16'h0007)), 32'h1_0002);
        chk("pin_xor",  32'(model(2'b00, 16'hA5A5, 16'h0F0F)), 32'h0_AAAA);
        chk("pin_wrap", 32'(model(2'b01, 16'hFFFF, 16'h0001)), 32'h1_0000);
`ifdef BOOTH_ADDSUB_SAT_EN
        chk("pin_ovf_add", 32'(model(2'b01, 16'h7FFF, 16'h0001)), 32'h2_7FFF);
        chk("pin_ovf_sub", 32'(model(2'b10, 16'h8000, 16'h0001)), 32'h3_8000);
`else
        chk("pin_ovf_add", 32'(model(2'b01, 16'h7FFF, 16'h0001)), 32'h2_8000);
        chk("pin_ovf_sub", 32'(model(2'b10, 16'h8000, 16'h0001)), 32'h3_7FFF);
`endif

        // 1: reset state, then latency of a single ADD
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_res",   32'(bus.out_res),   32'd0);
        chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
        chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b01;
        bus.in_x     = 16'h00FF;
        bus.in_y     = 16'h0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("latency_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_valid", 32'(bus.out_valid), 32'd1);
        chk("latency_res",   32'({bus.out_ovf, bus.out_carry, bus.out_res}), 32'h0_0100);
        wait_drain();

        // 2: back-to-back beats at full throughput
        base = cyc;
        send(2'b10, 16'h0005, 16'h0007);
        send(2'b11, 16'h0005, 16'h0007);
        send(2'b00, 16'hA5A5, 16'h0F0F);
        send(2'b01, 16'hFFFF, 16'h0001);
        chk("throughput_cycles", 32'(cyc - base), 32'd4);
        wait_drain();

        // 3: signed overflow
        send(2'b01, 16'h7FFF, 16'h0001);
        send(2'b10, 16'h8000, 16'h0001);
        send(2'b11, 16'h8000, 16'h7FFF);
        wait_drain();

        // 4: fill with out_ready low, then drain
        bus.out_ready = 1'b0;
        base = n_recv;
        n_push = 0;
        for (int i = 0; i < 4; i++) send(2'b01, 16'(16'h1000 * i), 16'h0F0F);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b10;
        bus.in_x     = 16'h4000;
        bus.in_y     = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready",  32'(bus.in_ready),  32'd0);
            chk("full_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("accepts_when_full", 32'(n_push), 32'd4);
        bus.out_ready = 1'b1;
        send(2'b10, 16'h4000, 16'h0001);
        send(2'b00, 16'hFFFF, 16'h1234);
        wait_drain();
        chk("drained_count", 32'(n_recv - base), 32'd6);

        // 5: random beats with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            op = 2'($urandom_range(0, 3));
            x  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
            send(op, x, y);
        end
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // 6: reset with beats in flight
        bus.out_ready = 1'b0;
        send(2'b01, 16'h1111, 16'h2222);
        send(2'b01, 16'h3333, 16'h4444);
        send(2'b10, 16'h5555, 16'h6666);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = n_recv;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        send(2'b01, 16'h1234, 16'h0101);
        wait_drain();
        chk("post_rst_recv", 32'(n_recv - base), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
